afifo_rd_sched: RTL and testbench

Read-side scheduler that shares the single read port of the asynchronous FIFO between `NUM_REQ` consumers in the read clock domain. It arbitrates round-robin, grants one consumer at a time, and issues bounded bursts of FIFO reads on its behalf. Each word is delivered with a valid strobe and the owning grant. It sits directly between the FIFO's read/empty/data pins and the downstream consumers.

---
 rtl/afifo_pkg.sv | 17 +
 rtl/afifo_rd_sched_rr_arbiter.sv | 30 +++
 rtl/afifo_rd_sched.sv | 103 ++++++++++
 tb/tb_afifo_rd_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async-FIFO read-side scheduler: FSM encoding and default word width.
// `bitLength normally comes from definitions.h; the fallback only keeps standalone builds compiling.
`ifndef bitLength
`define bitLength 32
`endif

package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = `bitLength;

endpackage

// File: rtl/afifo_rd_sched_rr_arbiter.sv
// Stateless round-robin pick: first requester at or after ptr, searching circularly.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/afifo_rd_sched.sv
// Shares the FIFO read port between NUM_REQ consumers: round-robin grant, bounded read
// bursts, and a one-cycle DRAIN so the last in-flight word still reaches its owner.
module afifo_rd_sched
  import afifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int BURST   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_fifo_rd,
  input  logic               i_fifo_empty,
  input  logic [WIDTH-1:0]   i_fifo_data,
  output logic               o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] gnt_q, arb_gnt;
  logic [IDX_W-1:0]   g_idx, rr_ptr, arb_idx;
  logic [CNT_W-1:0]   beat_cnt;
  logic               rd;
  logic               vld_p1;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req(i_req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) state_nx = READ;
      end
      READ: begin
        rd = i_req[g_idx] & ~i_fifo_empty & ~i_rst;
        if ((rd && beat_cnt == LAST_BEAT) || !i_req[g_idx] || i_fifo_empty)
          state_nx = DRAIN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= rd;
      case (state)
        IDLE: begin
          if (|i_req) begin
            gnt_q    <= arb_gnt;
            g_idx    <= arb_idx;
            beat_cnt <= '0;
          end
        end
        READ: begin
          if (rd) beat_cnt <= beat_cnt + 1'b1;
        end
        DRAIN: begin
          gnt_q  <= '0;
          rr_ptr <= next_ptr(g_idx);
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  // Outputs are forced low while reset is held so an in-flight word is never presented.
  assign o_gnt     = gnt_q & {NUM_REQ{~i_rst}};
  assign o_valid   = vld_p1 & ~i_rst;
  assign o_fifo_rd = rd;
  assign o_busy    = (state != IDLE) & ~i_rst;
  assign o_data    = i_fifo_data;

endmodule

// File: tb/tb_afifo_rd_sched.sv
// Directed bench for afifo_rd_sched with a behavioural FIFO (1-cycle read latency).
module tb_afifo_rd_sched;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         valid, fifo_rd, busy;
  logic [W-1:0] data;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_empty;

  logic [W-1:0] mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         rd_n   = 1'b0;
  logic         flush  = 1'b0;

  int tests = 0;
  int fails = 0;
  int uf_cnt = 0;
  int orphan_cnt = 0;
  logic [15:0] log_q[$];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         rd;
    logic         vld;
    logic [W-1:0] data;
    logic         busy;
  } vec_t;
  vec_t tbl[7];

  afifo_rd_sched #(.WIDTH(W), .NUM_REQ(N), .BURST(B)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .o_gnt       (gnt),
    .o_valid     (valid),
    .o_data      (data),
    .o_fifo_rd   (fifo_rd),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data (fifo_data),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (rd_n) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    rd_n = fifo_rd;
    if (fifo_rd && fifo_empty) uf_cnt++;
    if (fifo_rd && gnt == '0) orphan_cnt++;
    if (valid) log_q.push_back({4'(gnt), data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    log_q.delete();
  endtask

  function automatic logic [31:0] pack_out(input logic [N-1:0] g, input logic r, input logic v,
                                           input logic bz, input logic [W-1:0] d);
    return {17'd0, g, r, v, bz, (v ? d : 8'h00)};
  endfunction

  initial begin
    tbl[0] = '{req: 4'b0001, gnt: 4'b0000, rd: 1'b0, vld: 1'b0, data: 8'd0,  busy: 1'b0};
    tbl[1] = '{req: 4'b0001, gnt: 4'b0001, rd: 1'b1, vld: 1'b0, data: 8'd0,  busy: 1'b1};
    tbl[2] = '{req: 4'b0001, gnt: 4'b0001, rd: 1'b1, vld: 1'b1, data: 8'd10, busy: 1'b1};
    tbl[3] = '{req: 4'b0001, gnt: 4'b0001, rd: 1'b1, vld: 1'b1, data: 8'd20, busy: 1'b1};
    tbl[4] = '{req: 4'b0001, gnt: 4'b0001, rd: 1'b1, vld: 1'b1, data: 8'd30, busy: 1'b1};
    tbl[5] = '{req: 4'b0000, gnt: 4'b0001, rd: 1'b0, vld: 1'b1, data: 8'd40, busy: 1'b1};
    tbl[6] = '{req: 4'b0000, gnt: 4'b0000, rd: 1'b0, vld: 1'b0, data: 8'd0,  busy: 1'b0};

    // Outputs quiet while reset is held even with requests and data present
    rst = 1'b1;
    req = 4'b1111;
    push(8'd99);
    tick(); tick();
    @(negedge clk);
    check("reset_outputs", {28'd0, gnt, valid, fifo_rd, busy}, 32'd0);
    tick();

    // Single consumer, burst of 4 out of 5 queued words
    do_reset();
    push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      @(negedge clk);
      check($sformatf("burst_cyc%0d", i), pack_out(gnt, fifo_rd, valid, busy, data),
            pack_out(tbl[i].gnt, tbl[i].rd, tbl[i].vld, tbl[i].busy, tbl[i].data));
      tick();
    end
    check("burst_left_cnt", 32'(wr_ptr - rd_ptr), 32'd1);
    check("burst_left_word", {24'd0, mem[rd_ptr[5:0]]}, 32'd50);

    // All four requesting: grants rotate, 4 words each
    do_reset();
    for (int k = 0; k < 20; k++) push(8'(100 + k));
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 200; c++) begin
      if (log_q.size() >= 20) break;
      tick();
    end
    req = '0;
    check("rot_words", 32'(log_q.size()), 32'd20);
    for (int g = 0; g < 5; g++) begin
      logic [15:0] acc;
      logic [15:0] ref_v;
      acc = 16'h0;
      ref_v = 16'h0;
      for (int k = 0; k < 4; k++) begin
        if (g * 4 + k < log_q.size()) acc = acc ^ log_q[g * 4 + k] ^ 16'(k << 12);
        ref_v = ref_v ^ {4'(1 << (g % 4)), 8'(100 + g * 4 + k)} ^ 16'(k << 12);
      end
      check($sformatf("rot_grant%0d", g), {16'd0, acc}, {16'd0, ref_v});
    end
    tick(); tick();

    // Consumer 2 drops its request after the first read
    do_reset();
    push(8'd12); push(8'd16); push(8'd96);
    rst = 1'b0;
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) tick();
    req = '0;
    tick(); tick(); tick();
    check("drop_words", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("drop_w0", {16'd0, log_q[0]}, {16'd0, 4'b0100, 8'd12});
      check("drop_w1", {16'd0, log_q[1]}, {16'd0, 4'b0001, 8'd16});
      check("drop_w2", {16'd0, log_q[2]}, {16'd0, 4'b0001, 8'd96});
    end

    // Trickling data: empty FIFO releases the grant, next data goes to consumer 1
    do_reset();
    push(8'd77);
    rst = 1'b0;
    req = 4'b0011;
    tick(); tick(); tick();
    push(8'd88);
    tick(); tick(); tick(); tick();
    req = '0;
    tick(); tick(); tick(); tick();
    check("trickle_words", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("trickle_w0", {16'd0, log_q[0]}, {16'd0, 4'b0001, 8'd77});
      check("trickle_w1", {16'd0, log_q[1]}, {16'd0, 4'b0010, 8'd88});
    end

    // Reset mid-burst: in-flight word dropped, pointer back to consumer 0
    do_reset();
    for (int k = 0; k < 20; k++) push(8'(200 + k));
    rst = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    req = 4'b0001;
    tick();
    @(negedge clk);
    check("mid_idle_gnt", {28'd0, gnt}, 32'd0);
    tick();
    @(negedge clk);
    check("mid_read", {28'd0, gnt, fifo_rd}, {28'd0, 4'b0001, 1'b1});
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_during_rst", {28'd0, gnt, valid, fifo_rd, busy}, 32'd0);
    tick();
    rst = 1'b0;
    req = 4'b1001;
    @(negedge clk);
    check("mid_after_rst", {29'd0, valid, gnt == '0, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    tick();
    @(negedge clk);
    check("mid_rearb", {28'd0, gnt}, {28'd0, 4'b0001});
    tick();
    req = '0;
    for (int c = 0; c < 8; c++) tick();

    check("no_underflow", 32'(uf_cnt), 32'd0);
    check("no_orphan_read", 32'(orphan_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
